// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  // One display frame worth of data: four nibbles plus per-digit enable.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0]      en;
  } disp_buf_t;

  // Active-low segment patterns, bit0 = a .. bit6 = g; b and d are lower-case.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Lowest enabled digit index strictly above 'after'; MSB flags a hit.
  function automatic logic [IDX_W:0] next_enabled(input logic [NUM_DIGITS-1:0] en,
                                                  input int after);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--)
      if (i > after && en[i]) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_controller_seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Round-robin scan scheduler for a shared 4-digit seven-segment bus.
// Each slot opens with BLANK_CYCLES of all-anodes-off, then drives one digit.
// Digit data is double-buffered; shadow moves to active only at frame wrap.
// Optional build macro SEG_SCAN_SKIP_EN: skip slots of disabled digits.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [6:0]  seven_seg,
  output logic [3:0]  seven_enable,
  output logic        frame_start
);

  localparam int CW = $clog2(SLOT_CYCLES);

  scan_state_t state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             frame_edge;
  disp_buf_t        shadow, active, in_buf, next_frame;
  logic [NUM_DIGITS-1:0][6:0] dec_seg;
  logic [6:0]       seg_n;
  logic [3:0]       an_n;
`ifdef SEG_SCAN_SKIP_EN
  logic [IDX_W:0]   nx_hit, first_hit;
`endif

  assign in_buf     = {digits, digit_en};
  // Load on the wrap edge bypasses the shadow so the new value is shown at once.
  assign next_frame = load ? in_buf : shadow;

  // One decoder per digit; the slot mux selects which pattern reaches the bus.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decoder u_dec (.nibble(active.digits[g]), .seg(dec_seg[g]));
  end

  // Scan state, slot counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state: blank phase, drive phase, then advance to the next slot.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    idx_n      = idx;
    frame_edge = 1'b0;
`ifdef SEG_SCAN_SKIP_EN
    nx_hit     = next_enabled(active.en, int'(idx));
    first_hit  = next_enabled(next_frame.en, -1);
`endif
    case (state)
      BLANK: if (cnt == CW'(BLANK_CYCLES-1)) state_n = DRIVE;
      DRIVE: if (cnt == CW'(SLOT_CYCLES-1)) begin
        state_n = BLANK;
        cnt_n   = '0;
`ifdef SEG_SCAN_SKIP_EN
        if (active.en == '0) begin
          frame_edge = (idx == IDX_W'(NUM_DIGITS-1));
          idx_n      = idx + 1'b1;
        end else if (nx_hit[IDX_W]) begin
          idx_n = nx_hit[IDX_W-1:0];
        end else begin
          // No further enabled digit: wrap to the first enabled one of the new frame.
          frame_edge = 1'b1;
          idx_n      = first_hit[IDX_W-1:0];
        end
`else
        frame_edge = (idx == IDX_W'(NUM_DIGITS-1));
        idx_n      = idx + 1'b1;
`endif
      end
      default: state_n = BLANK;
    endcase
  end

  // Shadow captures every load; active only changes on the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load)       shadow <= in_buf;
      if (frame_edge) active <= next_frame;
    end
  end

  // Pin values for the current slot; everything off unless driving an enabled digit.
  always_comb begin
    seg_n = SEG_OFF;
    an_n  = AN_OFF;
    if (state == DRIVE && active.en[idx]) begin
      an_n[idx] = 1'b0;
      seg_n     = dec_seg[idx];
    end
  end

  // Registered pins, one clock behind the scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seven_seg    <= SEG_OFF;
      seven_enable <= AN_OFF;
      frame_start  <= 1'b0;
    end else begin
      seven_seg    <= seg_n;
      seven_enable <= an_n;
      frame_start  <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized self-checking bench for seg_scan_controller (fixed-rotation build).
module tb_seg_scan_controller;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [6:0]  seven_seg;
  logic [3:0]  seven_enable;
  logic        frame_start;

  seg_scan_controller #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .digits(digits), .digit_en(digit_en), .load(load),
    .seven_seg(seven_seg), .seven_enable(seven_enable), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Independent glyph table (active-low, a = bit0).
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time since reset release plus two buffers.
  int          n;
  logic [15:0] sh_d, ac_d;
  logic [3:0]  sh_e, ac_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @n=%0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; sh_d = '0; ac_d = '0; sh_e = '0; ac_e = '0;
  endtask

  // One clock: inputs set while clk low, pins checked 1 time unit after the edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] e);
    int pos, slot;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_fs;
    load = ld; digits = d; digit_en = e;
    @(posedge clk);
    pos     = n % SLOT;
    slot    = (n / SLOT) % 4;
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    if (pos >= BLANK && ac_e[slot]) begin
      exp_an  = ~(4'b0001 << slot);
      exp_seg = glyph[(ac_d >> (4 * slot)) & 16'hF];
    end
    exp_fs = ((n + 1) % FRAME) == 0;
    if (exp_fs) begin
      ac_d = ld ? d : sh_d;
      ac_e = ld ? e : sh_e;
    end
    if (ld) begin
      sh_d = d; sh_e = e;
    end
    n++;
    #1;
    chk("seg", 32'(seven_seg), 32'(exp_seg));
    chk("an", 32'(seven_enable), 32'(exp_an));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, digits, digit_en);
  endtask

  // Advance until the next edge processed will have model time n == v (mod FRAME).
  task automatic run_to(input int v);
    while (n % FRAME != v) step(1'b0, digits, digit_en);
  endtask

  // Never two anodes low together.
  always @(negedge clk)
    if (!rst) assert ($countones(~seven_enable) <= 1)
      else $error("two anodes low: %b", seven_enable);

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seven_seg), 32'h7F);
    chk("rst_an", 32'(seven_enable), 32'hF);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // First frame with empty buffers, then load 1234 all-enabled.
    idle(10);
    step(1'b1, 16'h1234, 4'hF);
    idle(2 * FRAME);

    // Sparse enable mask.
    step(1'b1, 16'hABCD, 4'b0101);
    idle(2 * FRAME);

    // Mid-frame load superseded by a load on the wrap edge.
    run_to(10);
    step(1'b1, 16'h5555, 4'hF);
    run_to(FRAME - 1);
    step(1'b1, 16'h6789, 4'hF);
    idle(FRAME + 5);

    // Async reset during a drive phase.
    run_to(BLANK + 3);
    chk("pre_rst_an", 32'(seven_enable != 4'hF), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_seg", 32'(seven_seg), 32'h7F);
    chk("async_an", 32'(seven_enable), 32'hF);
    chk("async_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 16'hFEDC, 4'hF);
    idle(FRAME + 10);

    // All 16 glyphs, four per frame.
    for (int f = 0; f < 4; f++) begin
      run_to(FRAME - 1);
      step(1'b1, {4'(4*f+3), 4'(4*f+2), 4'(4*f+1), 4'(4*f)}, 4'hF);
      idle(FRAME - 2);
    end

    // Randomized loads, including all-disabled masks.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0)
        step(1'b1, 16'($urandom), 4'($urandom));
      else
        step(1'b0, 16'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
